// File: rtl/neighbor_table_updater_if.sv
// Bus between the beacon parser, the neighbor-table updater and the data memory.
// master: the side issuing updates and serving memory reads; slave: the updater.
interface neighbor_table_updater_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  start;
  logic [WORD_WIDTH-1:0] pkt_neighborID;
  logic [WORD_WIDTH-1:0] pkt_clusterID;
  logic [WORD_WIDTH-1:0] pkt_batteryStat;
  logic [WORD_WIDTH-1:0] pkt_qValue;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] slot;
  logic                  new_entry;
  logic                  table_full;
  logic                  done;

  modport master (
    output start, pkt_neighborID, pkt_clusterID, pkt_batteryStat, pkt_qValue, data_in,
    input  address, wr_en, data_out, slot, new_entry, table_full, done
  );

  modport slave (
    input  start, pkt_neighborID, pkt_clusterID, pkt_batteryStat, pkt_qValue, data_in,
    output address, wr_en, data_out, slot, new_entry, table_full, done
  );
endinterface

// File: rtl/neighbor_table_updater.sv
// Neighbor-table writer: looks up a beacon sender in the shared table and either
// rewrites its fields in place or appends a new entry and bumps the count.
module neighbor_table_updater #(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    MAX_NEIGHBORS = 64,
  parameter logic [WORD_WIDTH-1:0] NID_BASE      = 'h48,
  parameter logic [WORD_WIDTH-1:0] CID_BASE      = 'hC8,
  parameter logic [WORD_WIDTH-1:0] BATT_BASE     = 'h148,
  parameter logic [WORD_WIDTH-1:0] QVAL_BASE     = 'h1C8,
  parameter logic [WORD_WIDTH-1:0] NCOUNT_ADDR   = 'h68A
) (
  input logic                      clock,
  input logic                      nrst,
  neighbor_table_updater_if.slave  bus
);

  // Index width must hold the value MAX_NEIGHBORS itself (the "full" count).
  localparam int IW = $clog2(MAX_NEIGHBORS + 1);
  localparam logic [IW-1:0] MAX_N = IW'(MAX_NEIGHBORS);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_CNT  = 4'd1;
  localparam logic [3:0] S_SEARCH  = 4'd2;
  localparam logic [3:0] S_APPEND  = 4'd3;
  localparam logic [3:0] S_WR_CID  = 4'd4;
  localparam logic [3:0] S_WR_BATT = 4'd5;
  localparam logic [3:0] S_WR_QVAL = 4'd6;
  localparam logic [3:0] S_WR_CNT  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]            state;
  logic [WORD_WIDTH-1:0] id_q, cid_q, batt_q, qval_q;
  logic [IW-1:0]         n_q;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         slot_q;
  logic                  new_entry_q, table_full_q, done_q, wr_en_q;
  logic [WORD_WIDTH-1:0] address_q, data_out_q;

  // Entries are 16-bit words, so entry i of a field lives at base + 2*i.
  function automatic logic [WORD_WIDTH-1:0] entry_addr(input logic [WORD_WIDTH-1:0] base,
                                                       input logic [IW-1:0]         idx);
    return base + (WORD_WIDTH'(idx) << 1);
  endfunction

  // Main FSM; every output is a register loaded on the transition into the state
  // that owns it, so a write is presented for exactly the cycle of its write state.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      id_q         <= '0;
      cid_q        <= '0;
      batt_q       <= '0;
      qval_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      slot_q       <= '0;
      new_entry_q  <= 1'b0;
      table_full_q <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      address_q    <= '0;
      data_out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the default below is simply
      // overridden by any later assignment in the write-state branches.
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            id_q         <= bus.pkt_neighborID;
            cid_q        <= bus.pkt_clusterID;
            batt_q       <= bus.pkt_batteryStat;
            qval_q       <= bus.pkt_qValue;
            slot_q       <= '0;
            new_entry_q  <= 1'b0;
            table_full_q <= 1'b0;
            address_q    <= NCOUNT_ADDR;
            state        <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          idx_q <= '0;
          // A corrupted count above capacity is clamped so the scan stays bounded.
          if (bus.data_in >= WORD_WIDTH'(MAX_NEIGHBORS)) n_q <= MAX_N;
          else                                           n_q <= bus.data_in[IW-1:0];
          if (bus.data_in == '0) begin
            // Empty table: append at slot 0, ID write happens in the APPEND cycle.
            slot_q      <= '0;
            new_entry_q <= 1'b1;
            wr_en_q     <= 1'b1;
            address_q   <= NID_BASE;
            data_out_q  <= id_q;
            state       <= S_APPEND;
          end else begin
            address_q <= NID_BASE;
            state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (bus.data_in == id_q) begin
            slot_q     <= idx_q;
            wr_en_q    <= 1'b1;
            address_q  <= entry_addr(CID_BASE, idx_q);
            data_out_q <= cid_q;
            state      <= S_WR_CID;
          end else if (idx_q + IW'(1) == n_q) begin
            if (n_q != MAX_N) begin
              slot_q      <= n_q;
              new_entry_q <= 1'b1;
              wr_en_q     <= 1'b1;
              address_q   <= entry_addr(NID_BASE, n_q);
              data_out_q  <= id_q;
            end
            state <= S_APPEND;
          end else begin
            idx_q     <= idx_q + IW'(1);
            address_q <= entry_addr(NID_BASE, idx_q + IW'(1));
          end
        end
        S_APPEND: begin
          if (n_q == MAX_N) begin
            table_full_q <= 1'b1;
            done_q       <= 1'b1;
            state        <= S_DONE;
          end else begin
            wr_en_q    <= 1'b1;
            address_q  <= entry_addr(CID_BASE, slot_q);
            data_out_q <= cid_q;
            state      <= S_WR_CID;
          end
        end
        S_WR_CID: begin
          wr_en_q    <= 1'b1;
          address_q  <= entry_addr(BATT_BASE, slot_q);
          data_out_q <= batt_q;
          state      <= S_WR_BATT;
        end
        S_WR_BATT: begin
          wr_en_q    <= 1'b1;
          address_q  <= entry_addr(QVAL_BASE, slot_q);
          data_out_q <= qval_q;
          state      <= S_WR_QVAL;
        end
        S_WR_QVAL: begin
          if (new_entry_q) begin
            wr_en_q    <= 1'b1;
            address_q  <= NCOUNT_ADDR;
            data_out_q <= WORD_WIDTH'(n_q) + WORD_WIDTH'(1);
            state      <= S_WR_CNT;
          end else begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_WR_CNT: begin
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          // Wait for start to drop so a held start cannot retrigger.
          if (!bus.start) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.address    = address_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.data_out   = data_out_q;
  assign bus.slot       = WORD_WIDTH'(slot_q);
  assign bus.new_entry  = new_entry_q;
  assign bus.table_full = table_full_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_neighbor_table_updater.sv
// Bench for neighbor_table_updater: a word-addressed memory model serves reads,
// expected writes and per-update results go into queues, a monitor checks them.
module tb_neighbor_table_updater;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] slot;
    logic        nw;
    logic        full;
    int          lat;
  } res_t;

  logic clock = 1'b0;
  logic nrst  = 1'b0;

  neighbor_table_updater_if #(.WORD_WIDTH(16)) bus();

  neighbor_table_updater dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory model: combinational read, write at the rising edge.
  logic [15:0] mem [0:2047];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [15:0] poke_data = '0;

  assign bus.data_in = mem[bus.address[11:1]];

  always @(posedge clock) begin
    if (poke_en)         mem[poke_addr[11:1]] <= poke_data;
    else if (bus.wr_en)  mem[bus.address[11:1]] <= bus.data_out;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   t_start = 0;
  logic done_prev = 1'b0;
  wr_t  exp_wr[$];
  res_t exp_res[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each write strobe and each done rise against the queues.
  always @(negedge clock) begin
    if (!nrst) begin
      done_prev = 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.address, bus.data_out);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", {16'h0, bus.address}, {16'h0, w.addr});
          check("wr_data", {16'h0, bus.data_out}, {16'h0, w.data});
        end
      end
      if (bus.done && !done_prev) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("slot",       {16'h0, bus.slot}, {16'h0, r.slot});
          check("new_entry",  {31'h0, bus.new_entry}, {31'h0, r.nw});
          check("table_full", {31'h0, bus.table_full}, {31'h0, r.full});
          check("latency",    cyc - t_start, r.lat);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic poke(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clock);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic exp_write(input logic [15:0] addr, input logic [15:0] data);
    exp_wr.push_back('{addr: addr, data: data});
  endtask

  // Issues one update, waits (bounded) for done, holds start, then releases it.
  task automatic run(input logic [15:0] id, input logic [15:0] cid, input logic [15:0] batt,
                     input logic [15:0] q, input logic [15:0] e_slot, input logic e_new,
                     input logic e_full, input int e_lat);
    int n;
    exp_res.push_back('{slot: e_slot, nw: e_new, full: e_full, lat: e_lat});
    @(negedge clock);
    bus.start           = 1'b1;
    bus.pkt_neighborID  = id;
    bus.pkt_clusterID   = cid;
    bus.pkt_batteryStat = batt;
    bus.pkt_qValue      = q;
    @(posedge clock);
    t_start = cyc;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.done && n < 200);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
    repeat (3) begin
      @(negedge clock);
      check("done_held", {31'h0, bus.done}, 32'h1);
    end
    bus.start = 1'b0;
    @(negedge clock);
    check("done_drop", {31'h0, bus.done}, 32'h0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_address"},    {16'h0, bus.address}, 32'h0);
    check({tag, "_wr_en"},      {31'h0, bus.wr_en}, 32'h0);
    check({tag, "_data_out"},   {16'h0, bus.data_out}, 32'h0);
    check({tag, "_slot"},       {16'h0, bus.slot}, 32'h0);
    check({tag, "_new_entry"},  {31'h0, bus.new_entry}, 32'h0);
    check({tag, "_table_full"}, {31'h0, bus.table_full}, 32'h0);
    check({tag, "_done"},       {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    int n;
    bus.start           = 1'b0;
    bus.pkt_neighborID  = '0;
    bus.pkt_clusterID   = '0;
    bus.pkt_batteryStat = '0;
    bus.pkt_qValue      = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    nrst = 1'b1;

    // Empty table: append at slot 0, count becomes 1.
    poke(16'h68A, 16'd0);
    exp_write(16'h048, 16'd7);
    exp_write(16'h0C8, 16'd2);
    exp_write(16'h148, 16'h4000);
    exp_write(16'h1C8, 16'h0140);
    exp_write(16'h68A, 16'd1);
    run(16'd7, 16'd2, 16'h4000, 16'h0140, 16'd0, 1'b1, 1'b0, 7);

    // Table {5,9,12}: update ID 9 in place at slot 1.
    poke(16'h048, 16'd5);
    poke(16'h04A, 16'd9);
    poke(16'h04C, 16'd12);
    poke(16'h68A, 16'd3);
    exp_write(16'h0CA, 16'h0011);
    exp_write(16'h14A, 16'h7FFF);
    exp_write(16'h1CA, 16'hFFE0);
    run(16'd9, 16'h0011, 16'h7FFF, 16'hFFE0, 16'd1, 1'b0, 1'b0, 7);

    // Unknown ID 20: append at slot 3, count 3 -> 4.
    exp_write(16'h04E, 16'd20);
    exp_write(16'h0CE, 16'd3);
    exp_write(16'h14E, 16'h1234);
    exp_write(16'h1CE, 16'h0020);
    exp_write(16'h68A, 16'd4);
    run(16'd20, 16'd3, 16'h1234, 16'h0020, 16'd3, 1'b1, 1'b0, 10);

    // ID 20 again: now found as the last entry (k=3).
    exp_write(16'h0CE, 16'd4);
    exp_write(16'h14E, 16'h2000);
    exp_write(16'h1CE, 16'h0040);
    run(16'd20, 16'd4, 16'h2000, 16'h0040, 16'd3, 1'b0, 1'b0, 9);

    // Full table of IDs 100..163: ID 99 is dropped with no writes.
    for (int i = 0; i < 64; i++) poke(16'h048 + 16'(2 * i), 16'(100 + i));
    poke(16'h68A, 16'd64);
    run(16'd99, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1, 67);

    // Count corrupted to 100: clamped to 64, still full.
    poke(16'h68A, 16'd100);
    run(16'd99, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1, 67);

    // Clamped count, match in the very last slot (k=63).
    exp_write(16'h146, 16'h0AAA);
    exp_write(16'h1C6, 16'h0BBB);
    exp_write(16'h246, 16'h0CCC);
    run(16'd163, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'd63, 1'b0, 1'b0, 69);

    // Reset asserted while the battery write is on the bus.
    poke(16'h048, 16'd5);
    poke(16'h04A, 16'd9);
    poke(16'h04C, 16'd12);
    poke(16'h68A, 16'd3);
    poke(16'h148, 16'hBEEF);
    exp_write(16'h0C8, 16'h0055);
    exp_write(16'h148, 16'h6666);
    @(negedge clock);
    bus.start           = 1'b1;
    bus.pkt_neighborID  = 16'd5;
    bus.pkt_clusterID   = 16'h0055;
    bus.pkt_batteryStat = 16'h6666;
    bus.pkt_qValue      = 16'h0077;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.wr_en && bus.address == 16'h148) && n < 50);
    check("reach_wr_batt", {31'h0, bus.wr_en}, 32'h1);
    #2 nrst = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("partial_cid", {16'h0, mem[16'h0C8 >> 1]}, 32'h0055);
    check("batt_untouched", {16'h0, mem[16'h148 >> 1]}, 32'hBEEF);
    bus.start = 1'b0;
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_idle_outputs("post_reset");

    // Fresh update after reset completes normally (ID 12 at k=2).
    exp_write(16'h0CC, 16'h0077);
    exp_write(16'h14C, 16'h0088);
    exp_write(16'h1CC, 16'h0099);
    run(16'd12, 16'h0077, 16'h0088, 16'h0099, 16'd2, 1'b0, 1'b0, 8);

    repeat (4) @(negedge clock);
    check("writes_drained", exp_wr.size(), 32'h0);
    check("results_drained", exp_res.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
